io_port_ctrl: RTL and testbench

- Buffered I/O port sitting directly on the datapath's ioOut/ioIn pins, between the CPU datapath and external peripherals.
- Output side: captures ioOut words on a control-unit strobe into an output FIFO and drains them to the peripheral over valid/ready.
- Input side: accepts peripheral words over valid/ready into an input FIFO and presents the head word on ioIn until the CPU pops it.

---
 rtl/io_port_ctrl_if.sv | 32 +++
 rtl/io_port_ctrl.sv | 105 ++++++++++
 tb/tb_io_port_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_ctrl_if.sv
// Datapath/peripheral signal bundle for io_port_ctrl.
// The slave modport is the port controller; the master modport is the
// datapath/control unit plus the external peripheral driving it.
interface io_port_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] ioOut;
  logic             out_wr;
  logic             out_full;
  logic             out_ovf;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic [WIDTH-1:0] ioIn;
  logic             in_empty;
  logic             in_rd;

  modport master (
    output ioOut, out_wr, ext_out_ready, ext_in_data, ext_in_valid, in_rd,
    input  out_full, out_ovf, ext_out_data, ext_out_valid, ext_in_ready,
           ioIn, in_empty
  );

  modport slave (
    input  ioOut, out_wr, ext_out_ready, ext_in_data, ext_in_valid, in_rd,
    output out_full, out_ovf, ext_out_data, ext_out_valid, ext_in_ready,
           ioIn, in_empty
  );
endinterface

// File: rtl/io_port_ctrl.sv
// Buffered I/O port: output FIFO (datapath -> peripheral) and input FIFO
// (peripheral -> datapath). Pointers carry one extra wrap bit so that
// occupancy 0..DEPTH is unambiguous.
// Optional feature macro: IO_LOOPBACK_EN adds a loopback input that routes
// the output FIFO head straight into the input FIFO.
//
// side state | meaning
// ST_EMPTY   | pointers equal, head forced to 0
// ST_PARTIAL | 1..DEPTH-1 words held
// ST_FULL    | DEPTH words held, further writes blocked
module io_port_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic Reset,
`ifdef IO_LOOPBACK_EN
  input logic loopback,
`endif
  io_port_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} side_state_e;

  logic [WIDTH-1:0] out_mem [DEPTH];
  logic [WIDTH-1:0] in_mem  [DEPTH];
  logic [AW:0]      out_wp, out_rp, in_wp, in_rp;
  logic             ovf_q;
  side_state_e      out_state, in_state;

  logic             push, drain, fill, pop, lb_active;
  logic [WIDTH-1:0] out_head, fill_data;

  // Per-side state is a pure decode of the pointers; nothing is stored.
  always_comb begin
    out_state = ST_PARTIAL;
    in_state  = ST_PARTIAL;
    if (out_wp == out_rp)
      out_state = ST_EMPTY;
    else if ((out_wp[AW-1:0] == out_rp[AW-1:0]) && (out_wp[AW] != out_rp[AW]))
      out_state = ST_FULL;
    if (in_wp == in_rp)
      in_state = ST_EMPTY;
    else if ((in_wp[AW-1:0] == in_rp[AW-1:0]) && (in_wp[AW] != in_rp[AW]))
      in_state = ST_FULL;
  end

`ifdef IO_LOOPBACK_EN
  assign lb_active = loopback;
`else
  assign lb_active = 1'b0;
`endif

  assign out_head = (out_state == ST_EMPTY) ? '0 : out_mem[out_rp[AW-1:0]];

  // Transfer qualifiers; fullness is judged on pre-edge pointers so a full
  // FIFO blocks a push even when it drains on the same edge.
  always_comb begin
    push      = bus.out_wr && (out_state != ST_FULL);
    pop       = bus.in_rd && (in_state != ST_EMPTY);
    drain     = 1'b0;
    fill      = 1'b0;
    fill_data = bus.ext_in_data;
    if (lb_active) begin
      drain     = (out_state != ST_EMPTY) && (in_state != ST_FULL);
      fill      = drain;
      fill_data = out_head;
    end else begin
      drain = (out_state != ST_EMPTY) && bus.ext_out_ready;
      fill  = bus.ext_in_valid && (in_state != ST_FULL);
    end
  end

  // Pointer and sticky overflow registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      out_wp <= '0;
      out_rp <= '0;
      in_wp  <= '0;
      in_rp  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push)  out_wp <= out_wp + 1'b1;
      if (drain) out_rp <= out_rp + 1'b1;
      if (fill)  in_wp  <= in_wp + 1'b1;
      if (pop)   in_rp  <= in_rp + 1'b1;
      if (bus.out_wr && (out_state == ST_FULL)) ovf_q <= 1'b1;
    end
  end

  // FIFO storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) out_mem[out_wp[AW-1:0]] <= bus.ioOut;
    if (fill) in_mem[in_wp[AW-1:0]]   <= fill_data;
  end

  assign bus.out_full      = (out_state == ST_FULL);
  assign bus.out_ovf       = ovf_q;
  assign bus.ext_out_data  = out_head;
  assign bus.ext_out_valid = (out_state != ST_EMPTY) && !lb_active;
  assign bus.ext_in_ready  = (in_state != ST_FULL) && !lb_active;
  assign bus.in_empty      = (in_state == ST_EMPTY);
  assign bus.ioIn          = (in_state == ST_EMPTY) ? '0 : in_mem[in_rp[AW-1:0]];
endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;
  logic clk;
  logic Reset;
  int   n_checks;
  int   n_errors;

  io_port_ctrl_if #(.WIDTH(16)) bus ();

`ifdef IO_LOOPBACK_EN
  logic loopback;
  io_port_ctrl #(.WIDTH(16), .DEPTH(4)) u_dut (
    .clk(clk), .Reset(Reset), .loopback(loopback), .bus(bus)
  );
`else
  io_port_ctrl #(.WIDTH(16), .DEPTH(4)) u_dut (
    .clk(clk), .Reset(Reset), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] dout;
    logic        ordy;
    logic        ivld;
    logic [15:0] din;
    logic        rd;
    logic        e_full;
    logic        e_ovf;
    logic        e_ovld;
    logic [15:0] e_odata;
    logic        e_irdy;
    logic        e_iempty;
    logic [15:0] e_ioin;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [15:0] dout, logic ordy,
                              logic ivld, logic [15:0] din, logic rd,
                              logic e_full, logic e_ovf, logic e_ovld,
                              logic [15:0] e_odata, logic e_irdy,
                              logic e_iempty, logic [15:0] e_ioin);
    vec_t v;
    v.wr = wr; v.dout = dout; v.ordy = ordy; v.ivld = ivld; v.din = din;
    v.rd = rd; v.e_full = e_full; v.e_ovf = e_ovf; v.e_ovld = e_ovld;
    v.e_odata = e_odata; v.e_irdy = e_irdy; v.e_iempty = e_iempty;
    v.e_ioin = e_ioin;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [15:0] dout, input logic ordy,
                       input logic ivld, input logic [15:0] din, input logic rd);
    @(negedge clk);
    bus.out_wr = wr; bus.ioOut = dout; bus.ext_out_ready = ordy;
    bus.ext_in_valid = ivld; bus.ext_in_data = din; bus.in_rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " out_full"},      {15'd0, bus.out_full},      {15'd0, v.e_full});
    check({tag, " out_ovf"},       {15'd0, bus.out_ovf},       {15'd0, v.e_ovf});
    check({tag, " ext_out_valid"}, {15'd0, bus.ext_out_valid}, {15'd0, v.e_ovld});
    check({tag, " ext_out_data"},  bus.ext_out_data,           v.e_odata);
    check({tag, " ext_in_ready"},  {15'd0, bus.ext_in_ready},  {15'd0, v.e_irdy});
    check({tag, " in_empty"},      {15'd0, bus.in_empty},      {15'd0, v.e_iempty});
    check({tag, " ioIn"},          bus.ioIn,                   v.e_ioin);
  endtask

  initial begin
    vec_t idle_rst;
    n_checks = 0;
    n_errors = 0;
`ifdef IO_LOOPBACK_EN
    loopback = 1'b0;
`endif
    bus.out_wr = 0; bus.ioOut = 0; bus.ext_out_ready = 0;
    bus.ext_in_valid = 0; bus.ext_in_data = 0; bus.in_rd = 0;
    Reset = 1'b0;
    idle_rst = mk(0,0,0,0,0,0, 0,0,0,16'h0,1,1,16'h0);

    // Reset held with random activity on every input.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.out_wr = 1'($urandom); bus.ioOut = 16'($urandom);
      bus.ext_out_ready = 1'($urandom); bus.ext_in_valid = 1'($urandom);
      bus.ext_in_data = 16'($urandom); bus.in_rd = 1'($urandom);
      @(posedge clk); #1;
      check_all($sformatf("rst%0d", i), idle_rst);
    end
    @(negedge clk);
    bus.out_wr = 0; bus.ext_out_ready = 0; bus.ext_in_valid = 0; bus.in_rd = 0;
    Reset = 1'b1;
    drive(0,0,0,0,0,0);
    check_all("post_rst", idle_rst);

    // wr dout ordy ivld din rd | full ovf ovld odata irdy iempty ioin
    vecs.push_back(mk(0,16'h0000,0, 0,16'h0000,0, 0,0,0,16'h0000, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h1111,0, 0,16'h0000,0, 0,0,1,16'h1111, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h2222,0, 0,16'h0000,0, 0,0,1,16'h1111, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h3333,0, 0,16'h0000,0, 0,0,1,16'h1111, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,0, 0,16'h0000,0, 0,0,1,16'h1111, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,0,1,16'h2222, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,0,1,16'h3333, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,0,0,16'h0000, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,0,0,16'h0000, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00A1,0, 0,16'h0000,0, 0,0,1,16'h00A1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00A2,0, 0,16'h0000,0, 0,0,1,16'h00A1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00A3,0, 0,16'h0000,0, 0,0,1,16'h00A1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00A4,0, 0,16'h0000,0, 1,0,1,16'h00A1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00A5,0, 0,16'h0000,0, 1,1,1,16'h00A1, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,1,1,16'h00A2, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,1,1,16'h00A3, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,1,1,16'h00A4, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,1,0,16'h0000, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00B1,0, 0,16'h0000,0, 0,1,1,16'h00B1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00B2,1, 0,16'h0000,0, 0,1,1,16'h00B2, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00B3,1, 0,16'h0000,0, 0,1,1,16'h00B3, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,1,0,16'h0000, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00C1,0, 0,16'h0000,0, 0,1,1,16'h00C1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00C2,0, 0,16'h0000,0, 0,1,1,16'h00C1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00C3,0, 0,16'h0000,0, 0,1,1,16'h00C1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00C4,0, 0,16'h0000,0, 1,1,1,16'h00C1, 1,1,16'h0000));
    vecs.push_back(mk(1,16'h00C5,1, 0,16'h0000,0, 0,1,1,16'h00C2, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,1,1,16'h00C3, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,1,1,16'h00C4, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,1, 0,16'h0000,0, 0,1,0,16'h0000, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,0, 1,16'hA0A0,0, 0,1,0,16'h0000, 1,0,16'hA0A0));
    vecs.push_back(mk(0,16'h0000,0, 1,16'hB0B0,0, 0,1,0,16'h0000, 1,0,16'hA0A0));
    vecs.push_back(mk(0,16'h0000,0, 0,16'h0000,1, 0,1,0,16'h0000, 1,0,16'hB0B0));
    vecs.push_back(mk(0,16'h0000,0, 0,16'h0000,1, 0,1,0,16'h0000, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,0, 0,16'h0000,1, 0,1,0,16'h0000, 1,1,16'h0000));
    vecs.push_back(mk(0,16'h0000,0, 1,16'h00E1,1, 0,1,0,16'h0000, 1,0,16'h00E1));
    vecs.push_back(mk(0,16'h0000,0, 0,16'h0000,1, 0,1,0,16'h0000, 1,1,16'h0000));

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].dout, vecs[i].ordy,
            vecs[i].ivld, vecs[i].din, vecs[i].rd);
      check_all($sformatf("v%0d", i), vecs[i]);
    end

    // Streaming fill+pop across pointer wrap: occupancy stays at one.
    for (int i = 0; i < 10; i++) begin
      logic [15:0] w;
      w = 16'h1000 + 16'(i) * 16'h0111;
      drive(0, 16'h0, 0, 1, w, (i != 0));
      check($sformatf("wrap%0d ioIn", i), bus.ioIn, w);
      check($sformatf("wrap%0d in_empty", i), {15'd0, bus.in_empty}, 16'h0);
      check($sformatf("wrap%0d ext_in_ready", i), {15'd0, bus.ext_in_ready}, 16'h1);
    end
    drive(0, 16'h0, 0, 0, 16'h0, 1);
    check("wrap_end in_empty", {15'd0, bus.in_empty}, 16'h1);
    check("wrap_end ioIn", bus.ioIn, 16'h0000);

    // Fill the input side to DEPTH; a further offer must be refused.
    for (int i = 0; i < 4; i++) begin
      drive(0, 16'h0, 0, 1, 16'hF000 + 16'(i), 0);
      check($sformatf("fill%0d ext_in_ready", i), {15'd0, bus.ext_in_ready},
            (i < 3) ? 16'h1 : 16'h0);
      check($sformatf("fill%0d ioIn", i), bus.ioIn, 16'hF000);
    end
    drive(0, 16'h0, 0, 1, 16'hF009, 0);
    check("fill_blocked ext_in_ready", {15'd0, bus.ext_in_ready}, 16'h0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 16'h0, 0, 0, 16'h0, 1);
      check($sformatf("drainin%0d ioIn", i), bus.ioIn,
            (i < 4) ? 16'hF000 + 16'(i) : 16'h0000);
      check($sformatf("drainin%0d ext_in_ready", i), {15'd0, bus.ext_in_ready}, 16'h1);
    end
    check("drainin in_empty", {15'd0, bus.in_empty}, 16'h1);

`ifdef IO_LOOPBACK_EN
    @(negedge clk);
    loopback = 1'b1;
    drive(1, 16'h00FF, 1, 1, 16'hDEAD, 0);
    check("lb push1 ext_out_valid", {15'd0, bus.ext_out_valid}, 16'h0);
    check("lb push1 ext_in_ready", {15'd0, bus.ext_in_ready}, 16'h0);
    drive(1, 16'hFF00, 1, 1, 16'hBEEF, 0);
    check("lb push2 ext_out_valid", {15'd0, bus.ext_out_valid}, 16'h0);
    drive(0, 16'h0, 1, 1, 16'hCAFE, 0);
    drive(0, 16'h0, 1, 0, 16'h0, 0);
    check("lb ioIn first", bus.ioIn, 16'h00FF);
    drive(0, 16'h0, 0, 0, 16'h0, 1);
    check("lb ioIn second", bus.ioIn, 16'hFF00);
    drive(0, 16'h0, 0, 0, 16'h0, 1);
    check("lb in_empty", {15'd0, bus.in_empty}, 16'h1);
    @(negedge clk);
    loopback = 1'b0;
`endif

    // Asynchronous reset mid-transfer discards everything and clears out_ovf.
    drive(1, 16'h5555, 0, 1, 16'h6666, 0);
    drive(1, 16'h7777, 0, 0, 16'h0, 0);
    check("pre_rst ext_out_valid", {15'd0, bus.ext_out_valid}, 16'h1);
    check("pre_rst out_ovf", {15'd0, bus.out_ovf}, 16'h1);
    #2;
    Reset = 1'b0;
    #1;
    check_all("async_rst", idle_rst);
    @(negedge clk);
    Reset = 1'b1;
    drive(0, 16'h0, 1, 0, 16'h0, 1);
    check_all("after_async_rst", idle_rst);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
